bus_arbit_rr4: RTL and testbench

Four-master round-robin bus arbiter with a bounded-tenure rule. It replaces the two-master arbiter in front of the shared slave bus. It produces one-hot grants and an encoded owner index, which drive the master-side address, write-enable and write-data muxes. A master holding the bus past its tenure limit is preempted whenever another master is requesting.

---
 rtl/bus_arbit_rr4_if.sv | 36 +++
 rtl/bus_arbit_rr4.sv | 91 +++++++++
 tb/tb_bus_arbit_rr4.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbit_rr4_if.sv
// Request/grant bundle between the four bus masters and the round-robin arbiter.
// M_lock exists only when BUS_ARB_LOCK_EN is defined.
interface bus_arbit_rr4_if;
    logic [3:0] M_req;
`ifdef BUS_ARB_LOCK_EN
    logic [3:0] M_lock;
`endif
    logic [3:0] M_grant;
    logic [1:0] M_sel;
    logic       bus_busy;
    logic [7:0] tenure_cnt;

    // Requesting side.
    modport master (
        output M_req,
`ifdef BUS_ARB_LOCK_EN
        output M_lock,
`endif
        input  M_grant,
        input  M_sel,
        input  bus_busy,
        input  tenure_cnt
    );

    // Arbiter side.
    modport slave (
        input  M_req,
`ifdef BUS_ARB_LOCK_EN
        input  M_lock,
`endif
        output M_grant,
        output M_sel,
        output bus_busy,
        output tenure_cnt
    );
endinterface

// File: rtl/bus_arbit_rr4.sv
// Four-master round-robin arbiter with bounded tenure; registered one-hot grant and owner index.
// Define BUS_ARB_LOCK_EN to add M_lock, which exempts the current owner from tenure preemption.
module bus_arbit_rr4 #(
    parameter int unsigned TENURE = 8
) (
    input logic           clk,
    input logic           reset,
    bus_arbit_rr4_if.slave bus
);
    localparam logic [7:0] Limit = 8'(TENURE - 1);

    typedef enum logic [0:0] {StIdle, StOwn} state_e;

    state_e     state_q;
    logic [1:0] last_q;
    logic [3:0] grant_q;
    logic [7:0] cnt_q;

    logic [3:0] lock;
    logic [3:0] others;
    logic       owner_req;
    logic       preempt;
    logic [1:0] next_idx;

`ifdef BUS_ARB_LOCK_EN
    assign lock = bus.M_lock;
`else
    assign lock = 4'b0000;
`endif

    // First set bit of mask searching from 'from'+1 upward, wrapping 3 -> 0.
    function automatic logic [1:0] next_req(input logic [1:0] from, input logic [3:0] mask);
        logic [1:0] idx;
        logic [1:0] res;
        res = from;
        for (int i = 4; i >= 1; i--) begin
            idx = from + 2'(i);
            if (mask[idx]) res = idx;
        end
        return res;
    endfunction

    always_comb begin
        // grant_q is zero when idle, so others covers every requester then.
        others    = bus.M_req & ~grant_q;
        owner_req = bus.M_req[last_q];
        preempt   = (state_q == StOwn) && owner_req && (|others) && (cnt_q >= Limit)
                    && !lock[last_q];
        next_idx  = next_req(last_q, others);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            last_q  <= 2'd3;
            grant_q <= 4'b0000;
            cnt_q   <= 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|bus.M_req) begin
                        state_q <= StOwn;
                        last_q  <= next_idx;
                        grant_q <= 4'b0001 << next_idx;
                        cnt_q   <= 8'd0;
                    end
                end
                StOwn: begin
                    if (!owner_req || preempt) begin
                        if (|others) begin
                            last_q  <= next_idx;
                            grant_q <= 4'b0001 << next_idx;
                        end else begin
                            state_q <= StIdle;
                            grant_q <= 4'b0000;
                        end
                        cnt_q <= 8'd0;
                    end else if (cnt_q != 8'd255) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.M_grant    = grant_q;
    assign bus.M_sel      = last_q;
    assign bus.bus_busy   = |grant_q;
    assign bus.tenure_cnt = cnt_q;
endmodule

// File: tb/tb_bus_arbit_rr4.sv
// Directed bench for bus_arbit_rr4: a per-cycle owner/tenure model plus hand-computed checkpoints.
module tb_bus_arbit_rr4;
    localparam int Tenure = 8;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    bit   started;

    bus_arbit_rr4_if bus();

    bus_arbit_rr4 #(.TENURE(Tenure)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner index (-1 when idle), cycles held minus one, most recent owner.
    int m_owner;
    int m_held;
    int m_last;

    function automatic int pick_after(input int from, input logic [3:0] mask);
        for (int off = 1; off <= 4; off++) begin
            if (mask[(from + off) % 4]) return (from + off) % 4;
        end
        return from;
    endfunction

    always @(posedge clk) begin
        logic [3:0] req;
        logic [3:0] others;
        logic       locked;
        req = bus.M_req;
        locked = 1'b0;
        started = 1'b1;
        if (reset) begin
            m_owner = -1;
            m_held  = 0;
            m_last  = 3;
        end else if (m_owner < 0) begin
            if (req != 0) begin
                m_owner = pick_after(m_last, req);
                m_last  = m_owner;
                m_held  = 0;
            end
        end else begin
            others = req;
            others[m_owner] = 1'b0;
`ifdef BUS_ARB_LOCK_EN
            locked = bus.M_lock[m_owner];
`endif
            if (!req[m_owner] || (others != 0 && m_held >= Tenure - 1 && !locked)) begin
                if (others != 0) begin
                    m_owner = pick_after(m_owner, others);
                    m_last  = m_owner;
                end else begin
                    m_owner = -1;
                end
                m_held = 0;
            end else if (m_held < 255) begin
                m_held = m_held + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_grant", int'(bus.M_grant), (m_owner < 0) ? 0 : (1 << m_owner));
            chk("model_sel", int'(bus.M_sel), m_last);
            chk("model_busy", int'(bus.bus_busy), (m_owner < 0) ? 0 : 1);
            chk("model_cnt", int'(bus.tenure_cnt), m_held);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad = 0;
        started = 1'b0;
        reset = 1'b1;
        bus.M_req = 4'b0000;
`ifdef BUS_ARB_LOCK_EN
        bus.M_lock = 4'b0000;
`endif
        step(2);
        chk("reset_grant", int'(bus.M_grant), 0);
        chk("reset_sel", int'(bus.M_sel), 3);
        chk("reset_busy", int'(bus.bus_busy), 0);
        chk("reset_cnt", int'(bus.tenure_cnt), 0);
        reset = 1'b0;

        // All four request continuously: each holds exactly Tenure cycles, M0 first.
        bus.M_req = 4'b1111;
        step(1);
        for (int j = 0; j < 40; j++) begin
            chk("rr_grant", int'(bus.M_grant), 1 << ((j / Tenure) % 4));
            chk("rr_sel", int'(bus.M_sel), (j / Tenure) % 4);
            chk("rr_cnt", int'(bus.tenure_cnt), j % Tenure);
            step(1);
        end
        bus.M_req = 4'b0000;
        step(1);

        // Single request from idle, then release.
        bus.M_req = 4'b0100;
        step(1);
        chk("m2_grant", int'(bus.M_grant), 4'b0100);
        chk("m2_cnt", int'(bus.tenure_cnt), 0);
        step(2);
        bus.M_req = 4'b0000;
        step(1);
        chk("m2_rel_grant", int'(bus.M_grant), 0);
        chk("m2_rel_cnt", int'(bus.tenure_cnt), 0);
        chk("m2_rel_sel", int'(bus.M_sel), 2);

        // Simultaneous release and new requests: M3 follows M1 with no gap.
        bus.M_req = 4'b0010;
        step(1);
        chk("m1_grant", int'(bus.M_grant), 4'b0010);
        bus.M_req = 4'b1001;
        step(1);
        chk("handover_grant", int'(bus.M_grant), 4'b1000);
        chk("handover_cnt", int'(bus.tenure_cnt), 0);
        bus.M_req = 4'b0000;
        step(1);

        // Sole requester keeps the bus past the limit; a newcomer wins at once.
        bus.M_req = 4'b0100;
        step(20);
        chk("sole_grant", int'(bus.M_grant), 4'b0100);
        chk("sole_cnt", int'(bus.tenure_cnt), 19);
        bus.M_req = 4'b0101;
        step(1);
        chk("late_grant", int'(bus.M_grant), 4'b0001);
        bus.M_req = 4'b0000;
        step(1);

        // Second requester arrives before the limit: preempted exactly at the limit.
        bus.M_req = 4'b0100;
        step(3);
        bus.M_req = 4'b1100;
        step(5);
        chk("limit_hold", int'(bus.M_grant), 4'b0100);
        chk("limit_cnt", int'(bus.tenure_cnt), Tenure - 1);
        step(1);
        chk("limit_preempt", int'(bus.M_grant), 4'b1000);
        bus.M_req = 4'b0000;
        step(1);

        // Reset mid-ownership.
        bus.M_req = 4'b0001;
        step(6);
        chk("pre_rst_cnt", int'(bus.tenure_cnt), 5);
        reset = 1'b1;
        step(1);
        chk("mid_rst_grant", int'(bus.M_grant), 0);
        chk("mid_rst_cnt", int'(bus.tenure_cnt), 0);
        chk("mid_rst_sel", int'(bus.M_sel), 3);
        reset = 1'b0;
        bus.M_req = 4'b0011;
        step(1);
        chk("post_rst_grant", int'(bus.M_grant), 4'b0001);
        bus.M_req = 4'b0000;
        step(1);

`ifdef BUS_ARB_LOCK_EN
        // Locked owner is never preempted; dropping the lock hands over next edge.
        bus.M_req  = 4'b0010;
        bus.M_lock = 4'b0010;
        step(1);
        bus.M_req = 4'b1010;
        step(11);
        chk("lock_hold", int'(bus.M_grant), 4'b0010);
        chk("lock_cnt", int'(bus.tenure_cnt), 11);
        bus.M_lock = 4'b0000;
        step(1);
        chk("unlock_grant", int'(bus.M_grant), 4'b1000);
        bus.M_req = 4'b0000;
        step(1);
`endif

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
